// File: rtl/cmd_sched.sv
// cmd_sched_fifo: circular command buffer, write on push, read head combinationally.
// Latency: a word pushed at edge N is visible at the head after edge N (cnt_o counts it).
// Backpressure: wr_rdy_o drops when full; a push still lands when a pop frees the slot that cycle.
module cmd_sched_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld_i,
    input  logic [W-1:0]  wr_dat_i,
    output logic          wr_rdy_o,
    input  logic          rd_pop_i,
    output logic [W-1:0]  rd_dat_o,
    output logic [CW-1:0] cnt_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          push;
    logic          pop;

    // wr_rdy_o is the conservative "not full" view; a simultaneous pop makes room for one more
    assign wr_rdy_o = (cnt_q != CW'(DEPTH));
    assign pop      = rd_pop_i && (cnt_q != '0);
    assign push     = wr_vld_i && (wr_rdy_o || pop);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign cnt_o    = cnt_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // Storage array; when full with a pop, the write reuses the slot just vacated by the head
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end
endmodule

// cmd_sched: round-robin arbiter between host FIFO and solver holding register for cmd_proc.
// Latency: word pushed at edge N drives cmd_rdy after edge N+1; resp/tmo pulses registered.
// Backpressure: host via h_rdy (FIFO not full), solver via s_rdy (holding register empty).
module cmd_sched #(
    parameter int DEPTH   = 4,
    parameter int TMO_CYC = 1000000,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   h_cmd,
    input  logic          h_vld,
    output logic          h_rdy,
    output logic [CW-1:0] h_cnt,
    input  logic [15:0]   s_cmd,
    input  logic          s_vld,
    output logic          s_rdy,
    output logic [15:0]   cmd,
    output logic          cmd_rdy,
    input  logic          clr_cmd_rdy,
    input  logic          send_resp,
    output logic          h_resp,
    output logic          s_resp,
    output logic          tmo,
    output logic          busy
);
    localparam int            TW       = $clog2(TMO_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic          SRC_HOST = 1'b0;
    localparam logic          SRC_SOLV = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, cmd_rdy_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          h_resp_q, h_resp_d;
    logic          s_resp_q, s_resp_d;
    logic          tmo_q, tmo_d;

    logic          s_full_q;
    logic [15:0]   s_dat_q;

    logic [15:0]   h_head;
    logic          h_pop;
    logic          s_clr;
    logic          h_pend;
    logic          s_pend;
    logic          pick_host;

    cmd_sched_fifo #(
        .W     (16),
        .DEPTH (DEPTH)
    ) u_host_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld_i (h_vld),
        .wr_dat_i (h_cmd),
        .wr_rdy_o (h_rdy),
        .rd_pop_i (h_pop),
        .rd_dat_o (h_head),
        .cnt_o    (h_cnt)
    );

    assign h_pend    = (h_cnt != '0);
    assign s_pend    = s_full_q;
    // Host wins when it is the only requester or when the solver had the previous grant
    assign pick_host = h_pend && (!s_pend || (last_grant_q == SRC_SOLV));

    // Solver holding register: loads only when empty, empties when its command is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_full_q <= 1'b0;
            s_dat_q  <= '0;
        end else if (s_clr) begin
            s_full_q <= 1'b0;
        end else if (s_vld && !s_full_q) begin
            s_full_q <= 1'b1;
            s_dat_q  <= s_cmd;
        end
    end

    // Scheduler next-state: arbitrate in IDLE, hold until accept, then watch for response or timeout
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        h_resp_d     = 1'b0;
        s_resp_d     = 1'b0;
        tmo_d        = 1'b0;
        h_pop        = 1'b0;
        s_clr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (h_pend || s_pend) begin
                    if (pick_host) begin
                        cmd_d        = h_head;
                        owner_d      = SRC_HOST;
                        last_grant_d = SRC_HOST;
                    end else begin
                        cmd_d        = s_dat_q;
                        owner_d      = SRC_SOLV;
                        last_grant_d = SRC_SOLV;
                    end
                    cmd_rdy_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // The source entry stays queued until cmd_proc takes it, so h_cnt still counts it
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    timer_d   = '0;
                    if (owner_q == SRC_HOST) begin
                        h_pop = 1'b1;
                    end else begin
                        s_clr = 1'b1;
                    end
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
                // A completion arriving on the last watchdog cycle still counts as success
                if (send_resp) begin
                    h_resp_d = (owner_q == SRC_HOST);
                    s_resp_d = (owner_q == SRC_SOLV);
                    state_d  = IDLE;
                end else if (timer_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state register; reset drops any in-flight command without a pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
            owner_q      <= SRC_HOST;
            last_grant_q <= SRC_SOLV;
            timer_q      <= '0;
            h_resp_q     <= 1'b0;
            s_resp_q     <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_rdy_q    <= cmd_rdy_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            h_resp_q     <= h_resp_d;
            s_resp_q     <= s_resp_d;
            tmo_q        <= tmo_d;
        end
    end

    assign s_rdy   = !s_full_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign h_resp  = h_resp_q;
    assign s_resp  = s_resp_q;
    assign tmo     = tmo_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_cmd_sched.sv
// tb_cmd_sched: vector table, directed corner sequences and random traffic against a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: host/solver pushes issued freely; model decides acceptance.
module tb_cmd_sched;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] h_cmd = '0;
    logic        h_vld = 1'b0;
    logic        h_rdy;
    logic [2:0]  h_cnt;
    logic [15:0] s_cmd = '0;
    logic        s_vld = 1'b0;
    logic        s_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr = 1'b0;
    logic        send = 1'b0;
    logic        h_resp;
    logic        s_resp;
    logic        tmo;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmd_sched #(.DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cmd       (h_cmd),
        .h_vld       (h_vld),
        .h_rdy       (h_rdy),
        .h_cnt       (h_cnt),
        .s_cmd       (s_cmd),
        .s_vld       (s_vld),
        .s_rdy       (s_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr),
        .send_resp   (send),
        .h_resp      (h_resp),
        .s_resp      (s_resp),
        .tmo         (tmo),
        .busy        (busy)
    );

    // ---------------- reference model (queues + phase) ----------------
    logic [15:0] hq[$];
    bit          s_has = 0;
    logic [15:0] s_word = '0;
    int          phase = 0;      // 0 idle, 1 offered to cmd_proc, 2 awaiting completion
    logic [15:0] m_cmd = '0;
    bit          m_cmd_rdy = 0;
    bit          owner_solver = 0;
    bit          last_solver = 1;
    int          waited = 0;
    bit          m_hresp = 0, m_sresp = 0, m_tmo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit pop_h, clr_s, acc;
        pop_h = 0;
        clr_s = 0;
        m_hresp = 0;
        m_sresp = 0;
        m_tmo = 0;
        if (!rst_n) begin
            hq.delete();
            s_has = 0;
            phase = 0;
            m_cmd = '0;
            m_cmd_rdy = 0;
            owner_solver = 0;
            last_solver = 1;
            waited = 0;
            return;
        end
        if (phase == 0) begin
            if (hq.size() > 0 || s_has) begin
                owner_solver = !(hq.size() > 0 && (!s_has || last_solver));
                m_cmd = owner_solver ? s_word : hq[0];
                last_solver = owner_solver;
                m_cmd_rdy = 1;
                phase = 1;
            end
        end else if (phase == 1) begin
            if (clr) begin
                m_cmd_rdy = 0;
                if (owner_solver) clr_s = 1; else pop_h = 1;
                waited = 0;
                phase = 2;
            end
        end else begin
            if (send) begin
                if (owner_solver) m_sresp = 1; else m_hresp = 1;
                phase = 0;
            end else if (waited == TMO - 1) begin
                m_tmo = 1;
                phase = 0;
            end else begin
                waited++;
            end
        end
        acc = h_vld && (hq.size() < DEPTH || pop_h);
        if (pop_h) void'(hq.pop_front());
        if (acc) hq.push_back(h_cmd);
        if (clr_s) s_has = 0;
        else if (s_vld && !s_has) begin
            s_has = 1;
            s_word = s_cmd;
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic [2:0] n;
        n = 3'(hq.size());
        return {6'd0, (hq.size() < DEPTH), n, !s_has, m_cmd, m_cmd_rdy, m_hresp, m_sresp, m_tmo, (phase != 0)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {6'd0, h_rdy, h_cnt, s_rdy, cmd, cmd_rdy, h_resp, s_resp, tmo, busy};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model", dut_vec(), exp_vec());
    endtask

    task automatic do_reset();
        rst_n = 1'b0; h_vld = 0; s_vld = 0; clr = 0; send = 0;
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for an offer, accept it, then complete it; returns the issued word
    task automatic serve(output logic [15:0] w);
        int n;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("serve_offer", {31'd0, cmd_rdy}, 32'd1);
        w = cmd;
        clr = 1; tick(); clr = 0;
        send = 1; tick(); send = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n, h_vld;
        logic [15:0] h_cmd;
        logic        s_vld;
        logic [15:0] s_cmd;
        logic        clr, send;
        logic        e_cmd_rdy;
        logic [15:0] e_cmd;
        logic [2:0]  e_cnt;
        logic        e_s_rdy, e_hresp, e_sresp, e_busy;
    } vec_t;

    function automatic vec_t mk(logic r, logic hv, logic [15:0] hc, logic sv, logic [15:0] sc,
                                logic c, logic sr, logic ecr, logic [15:0] ec, logic [2:0] en,
                                logic esr, logic ehr, logic esp, logic eb);
        vec_t v;
        v.rst_n = r; v.h_vld = hv; v.h_cmd = hc; v.s_vld = sv; v.s_cmd = sc; v.clr = c; v.send = sr;
        v.e_cmd_rdy = ecr; v.e_cmd = ec; v.e_cnt = en; v.e_s_rdy = esr;
        v.e_hresp = ehr; v.e_sresp = esp; v.e_busy = eb;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        logic [15:0] w;
        logic [15:0] exp_order[4];
        int n;
        bit saw_hresp;

        //            rst hv hcmd     sv scmd     clr snd  cr  cmd     cnt srdy hr sr busy
        tbl[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 16'h2000, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h2000, 1, 1, 0, 0, 1);
        tbl[3]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 1,   1, 16'h2000, 1, 1, 0, 0, 1);
        tbl[4]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 0,   0, 16'h2000, 0, 1, 0, 0, 1);
        tbl[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h2000, 0, 1, 0, 0, 1);
        tbl[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 1,   0, 16'h2000, 0, 1, 1, 0, 0);
        tbl[7]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h2000, 0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 1, 16'h4003, 1, 16'h6000, 0, 0,   0, 16'h0000, 1, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h4003, 1, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 0,   0, 16'h4003, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 1,   0, 16'h4003, 0, 0, 1, 0, 0);
        tbl[13] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0,   1, 16'h6000, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 0,   0, 16'h6000, 0, 1, 0, 0, 1);
        tbl[15] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 1,   0, 16'h6000, 0, 1, 0, 1, 0);
        tbl[16] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0,   0, 16'h6000, 0, 1, 0, 0, 0);

        rst_n = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 17; i++) begin
            rst_n = tbl[i].rst_n; h_vld = tbl[i].h_vld; h_cmd = tbl[i].h_cmd;
            s_vld = tbl[i].s_vld; s_cmd = tbl[i].s_cmd; clr = tbl[i].clr; send = tbl[i].send;
            tick();
            check($sformatf("vec%0d", i),
                  {7'd0, cmd_rdy, cmd, h_cnt, s_rdy, h_resp, s_resp, busy},
                  {7'd0, tbl[i].e_cmd_rdy, tbl[i].e_cmd, tbl[i].e_cnt, tbl[i].e_s_rdy,
                   tbl[i].e_hresp, tbl[i].e_sresp, tbl[i].e_busy});
        end
        h_vld = 0; s_vld = 0; clr = 0; send = 0;

        // Full FIFO: 5th push dropped, push+pop while full keeps count and queues new word last
        do_reset();
        for (int i = 0; i < 4; i++) begin
            h_vld = 1; h_cmd = 16'hA000 + 16'(i);
            tick();
        end
        check("full_cnt", {29'd0, h_cnt}, 32'd4);
        check("full_rdy", {31'd0, h_rdy}, 32'd0);
        h_cmd = 16'hA004;
        tick();
        check("overflow_cnt", {29'd0, h_cnt}, 32'd4);
        h_cmd = 16'hB000; clr = 1;
        tick();
        h_vld = 0; clr = 0;
        check("pushpop_cnt", {29'd0, h_cnt}, 32'd4);
        send = 1; tick(); send = 0;
        exp_order[0] = 16'hA001; exp_order[1] = 16'hA002;
        exp_order[2] = 16'hA003; exp_order[3] = 16'hB000;
        for (int i = 0; i < 4; i++) begin
            serve(w);
            check($sformatf("order%0d", i), {16'd0, w}, {16'd0, exp_order[i]});
        end
        check("drained_cnt", {29'd0, h_cnt}, 32'd0);

        // Watchdog: tmo exactly TMO cycles after entering the wait, then next command issues
        do_reset();
        h_vld = 1; h_cmd = 16'hC001; tick();
        h_cmd = 16'hC002; tick();
        h_vld = 0;
        clr = 1; tick(); clr = 0;
        n = 0;
        saw_hresp = 0;
        while (tmo !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (h_resp === 1'b1) saw_hresp = 1;
        end
        check("tmo_latency", n, TMO);
        check("tmo_no_resp", {31'd0, saw_hresp}, 32'd0);
        tick();
        check("after_tmo_issue", {15'd0, cmd_rdy, cmd}, {15'd0, 1'b1, 16'hC002});

        // Reset while waiting with two commands queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            h_vld = 1; h_cmd = 16'hD001 + 16'(i);
            tick();
        end
        h_vld = 0;
        clr = 1; tick(); clr = 0;
        tick();
        check("pre_rst_cnt", {29'd0, h_cnt}, 32'd2);
        rst_n = 0; send = 1;
        tick();
        rst_n = 1; send = 0;
        check("rst_state", {11'd0, busy, h_cnt, cmd_rdy, h_resp, s_resp, tmo, cmd},
              32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("rst_dropped", {30'd0, cmd_rdy, busy}, 32'd0);

        // Completion on the final watchdog cycle beats the timeout
        do_reset();
        h_vld = 1; h_cmd = 16'hE001; tick();
        h_vld = 0; tick();
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < TMO - 1; i++) tick();
        send = 1; tick(); send = 0;
        check("edge_resp", {30'd0, h_resp, tmo}, {30'd0, 1'b1, 1'b0});

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            h_vld = ($urandom_range(0, 1) == 1);
            h_cmd = 16'($urandom);
            s_vld = ($urandom_range(0, 9) < 3);
            s_cmd = 16'($urandom);
            clr   = ($urandom_range(0, 9) < 3);
            send  = ($urandom_range(0, 9) < 2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
